// File: rtl/uart_pkg.sv
// Shared constants and state encoding for the UART receive-path blocks.
package uart_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        ACCUM,
        WRITE,
        FULL
    } packer_state_t;

endpackage

// File: rtl/uart_rx_word_packer.sv
// Packs received UART bytes little-endian into RAM words and writes them sequentially on port A.
// Tracks stored word count, full and sticky drop flags until the next clear or reset.
module uart_rx_word_packer
    import uart_pkg::*;
#(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    input  logic                  rx_err,
    input  logic                  flush,
    input  logic                  clear,
    output logic                  ram_en,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_din,
    output logic [ADDR_WIDTH:0]   word_count,
    output logic                  full,
    output logic                  overflow,
    output logic                  rx_err_seen
);

    localparam int BYTES  = DATA_WIDTH / BYTE_W;
    localparam int LANE_W = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam logic [LANE_W-1:0]   LP_LANE_LAST  = LANE_W'(BYTES - 1);
    localparam logic [ADDR_WIDTH:0] LP_COUNT_LAST = (ADDR_WIDTH + 1)'((2 ** ADDR_WIDTH) - 1);

    packer_state_t         r_state;
    packer_state_t         w_state_next;
    logic [LANE_W-1:0]     r_lane;
    logic [DATA_WIDTH-1:0] r_asm;
    logic [DATA_WIDTH-1:0] r_din;
    logic [ADDR_WIDTH-1:0] r_ptr;
    logic [ADDR_WIDTH:0]   r_count;
    logic                  r_overflow;
    logic                  r_err_seen;

    logic                  w_full;
    logic                  w_strobe;
    logic                  w_accept;
    logic                  w_complete;
    logic                  w_flush_go;
    logic                  w_launch;
    logic [LANE_W-1:0]     w_lane_after;
    logic [DATA_WIDTH-1:0] w_asm_byte;
    logic [DATA_WIDTH-1:0] w_word;

    // Unwritten lanes of r_asm are always zero, so OR-ing in a byte also gives flush zero-padding.
    always_comb begin
        w_full       = (r_state == FULL);
        w_strobe     = (r_state == WRITE);
        w_accept     = rx_valid && !rx_err && !w_full;
        w_asm_byte   = r_asm | (DATA_WIDTH'(rx_data) << (BYTE_W * int'(r_lane)));
        w_complete   = w_accept && (r_lane == LP_LANE_LAST);
        w_lane_after = r_lane;
        if (w_accept) begin
            w_lane_after = w_complete ? '0 : (r_lane + LANE_W'(1));
        end
        w_flush_go = flush && !w_full && !w_complete && (w_lane_after != '0);
        w_word     = w_accept ? w_asm_byte : r_asm;
        w_launch   = w_complete || w_flush_go;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ACCUM;
        end else begin
            r_state <= w_state_next;
        end
    end

    // A launch requested during the final slot's strobe is dropped: the RAM is full from then on.
    always_comb begin
        w_state_next = r_state;
        if (clear) begin
            w_state_next = ACCUM;
        end else begin
            case (r_state)
                ACCUM:   w_state_next = w_launch ? WRITE : ACCUM;
                WRITE: begin
                    if (r_count == LP_COUNT_LAST) begin
                        w_state_next = FULL;
                    end else begin
                        w_state_next = w_launch ? WRITE : ACCUM;
                    end
                end
                FULL:    w_state_next = FULL;
                default: w_state_next = ACCUM;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            r_lane     <= '0;
            r_asm      <= '0;
            r_din      <= '0;
            r_ptr      <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
            r_err_seen <= 1'b0;
        end else begin
            if (w_strobe) begin
                r_ptr   <= r_ptr + ADDR_WIDTH'(1);
                r_count <= r_count + (ADDR_WIDTH + 1)'(1);
            end
            if (rx_valid && rx_err) begin
                r_err_seen <= 1'b1;
            end
            if (rx_valid && !rx_err && w_full) begin
                r_overflow <= 1'b1;
            end
            if (w_launch) begin
                r_din  <= w_word;
                r_asm  <= '0;
                r_lane <= '0;
            end else if (w_accept) begin
                r_asm  <= w_asm_byte;
                r_lane <= w_lane_after;
            end
        end
    end

    assign ram_en      = w_strobe;
    assign ram_we      = w_strobe;
    assign ram_addr    = r_ptr;
    assign ram_din     = r_din;
    assign word_count  = r_count;
    assign full        = w_full;
    assign overflow    = r_overflow;
    assign rx_err_seen = r_err_seen;

endmodule

// File: tb/tb_uart_rx_word_packer.sv
// Self-checking bench for uart_rx_word_packer: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a queue-based byte/word model.
module tb_uart_rx_word_packer;

    localparam int AW    = 2;
    localparam int DW    = 32;
    localparam int BYTES = DW / 8;
    localparam int CAP   = 2 ** AW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [7:0]    rx_data = 8'h00;
    logic          rx_valid = 1'b0;
    logic          rx_err = 1'b0;
    logic          flush = 1'b0;
    logic          clear = 1'b0;
    logic          ram_en;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_din;
    logic [AW:0]   word_count;
    logic          full;
    logic          overflow;
    logic          rx_err_seen;

    int checks = 0;
    int errors = 0;
    bit started = 0;

    uart_rx_word_packer #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_err     (rx_err),
        .flush      (flush),
        .clear      (clear),
        .ram_en     (ram_en),
        .ram_we     (ram_we),
        .ram_addr   (ram_addr),
        .ram_din    (ram_din),
        .word_count (word_count),
        .full       (full),
        .overflow   (overflow),
        .rx_err_seen(rx_err_seen)
    );

    always #5 clk = ~clk;

    // Behavioural model: pending bytes kept in a queue, words formed when it holds BYTES entries or on flush.
    logic [7:0]  m_q[$];
    int          m_count = 0;
    int          m_ptr = 0;
    bit          m_full = 0;
    bit          m_ovf = 0;
    bit          m_err = 0;
    bit          m_en = 0;
    logic [31:0] m_din = 32'h0;

    always @(posedge clk) begin
        bit          was_full;
        bit          want;
        logic [31:0] w;
        if (!rst_n || clear) begin
            m_q.delete();
            m_count = 0;
            m_ptr   = 0;
            m_full  = 0;
            m_ovf   = 0;
            m_err   = 0;
            m_en    = 0;
            m_din   = 32'h0;
        end else begin
            was_full = m_full;
            want     = 0;
            w        = 32'h0;
            if (m_en) begin
                m_count++;
                m_ptr = (m_ptr + 1) % CAP;
                if (m_count == CAP) m_full = 1;
            end
            if (rx_valid) begin
                if (rx_err) m_err = 1;
                else if (was_full) m_ovf = 1;
                else m_q.push_back(rx_data);
            end
            if (m_q.size() == BYTES || (flush && !was_full && m_q.size() > 0)) begin
                for (int i = 0; i < m_q.size(); i++) w = w | (32'(m_q[i]) << (8 * i));
                m_q.delete();
                want = 1;
            end
            m_en = want && !m_full;
            if (want) m_din = w;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (started) begin
            chk("model ram_en", 32'(ram_en), 32'(m_en));
            chk("model ram_we", 32'(ram_we), 32'(m_en));
            if (m_en) begin
                chk("model ram_addr", 32'(ram_addr), 32'(m_ptr));
                chk("model ram_din", ram_din, m_din);
            end
            chk("model word_count", 32'(word_count), 32'(m_count));
            chk("model full", 32'(full), 32'(m_full));
            chk("model overflow", 32'(overflow), 32'(m_ovf));
            chk("model rx_err_seen", 32'(rx_err_seen), 32'(m_err));
        end
    end

    task automatic step(input logic v, input logic [7:0] d, input logic e,
                        input logic f, input logic c, input logic r);
        rx_valid = v;
        rx_data  = d;
        rx_err   = e;
        flush    = f;
        clear    = c;
        rst_n    = r;
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] d);
        step(1'b1, d, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic idle();
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, " ram_en"}, 32'(ram_en), 32'h0);
        chk({tag, " word_count"}, 32'(word_count), 32'h0);
        chk({tag, " full"}, 32'(full), 32'h0);
        chk({tag, " overflow"}, 32'(overflow), 32'h0);
        chk({tag, " rx_err_seen"}, 32'(rx_err_seen), 32'h0);
    endtask

    initial begin
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        started = 1;
        chk_zero("reset");

        send(8'h11); send(8'h22); send(8'h33); send(8'h44);
        chk("w0 strobe", 32'(ram_en), 32'h1);
        chk("w0 addr", 32'(ram_addr), 32'h0);
        chk("w0 din", ram_din, 32'h44332211);
        chk("w0 model din", m_din, 32'h44332211);
        idle();
        chk("w0 count", 32'(word_count), 32'h1);
        chk("w0 strobe one cycle", 32'(ram_en), 32'h0);

        send(8'hAA); send(8'hBB);
        step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1);
        chk("flush strobe", 32'(ram_en), 32'h1);
        chk("flush addr", 32'(ram_addr), 32'h1);
        chk("flush din", ram_din, 32'h0000BBAA);
        idle();
        step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1);
        chk("empty flush no strobe", 32'(ram_en), 32'h0);
        chk("flush count", 32'(word_count), 32'h2);

        send(8'h01);
        step(1'b1, 8'hEE, 1'b1, 1'b0, 1'b0, 1'b1);
        chk("err seen", 32'(rx_err_seen), 32'h1);
        send(8'h02); send(8'h03); send(8'h04);
        chk("err word strobe", 32'(ram_en), 32'h1);
        chk("err word addr", 32'(ram_addr), 32'h2);
        chk("err word din", ram_din, 32'h04030201);

        send(8'h05); send(8'h06); send(8'h07); send(8'h08);
        chk("last slot addr", 32'(ram_addr), 32'h3);
        idle();
        chk("full flag", 32'(full), 32'h1);
        chk("full count", 32'(word_count), 32'h4);
        for (int i = 0; i < BYTES; i++) begin
            send(8'h90 + 8'(i));
            chk("no write while full", 32'(ram_en), 32'h0);
        end
        idle();
        chk("no write after overflow", 32'(ram_en), 32'h0);
        chk("overflow flag", 32'(overflow), 32'h1);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1);
        chk_zero("clear");

        for (int i = 0; i < 8; i++) begin
            send(8'h10 + 8'(i));
            if (i == 3) begin
                chk("b2b first addr", 32'(ram_addr), 32'h0);
                chk("b2b first din", ram_din, 32'h13121110);
            end
        end
        chk("b2b second strobe", 32'(ram_en), 32'h1);
        chk("b2b second addr", 32'(ram_addr), 32'h1);
        chk("b2b second din", ram_din, 32'h17161514);
        idle();
        chk("b2b count", 32'(word_count), 32'h2);

        send(8'hA1); send(8'hA2);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        chk_zero("mid-word reset");
        send(8'hC1); send(8'hC2); send(8'hC3); send(8'hC4);
        chk("post-reset addr", 32'(ram_addr), 32'h0);
        chk("post-reset din", ram_din, 32'hC4C3C2C1);

        for (int n = 0; n < 4000; n++) begin
            step($urandom_range(0, 99) < 65,
                 8'($urandom),
                 $urandom_range(0, 99) < 6,
                 $urandom_range(0, 99) < 8,
                 $urandom_range(0, 79) == 0,
                 $urandom_range(0, 499) != 0);
        end
        idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
